// File: rtl/kamacore_mem_arbiter.sv
// Arbiter sharing the unified instruction/data RAM port between fetch and load/store.
// Define KAMACORE_ARB_ROUND_ROBIN_EN for round-robin on contention; default is data-over-fetch priority.
module kamacore_mem_arbiter #(
  parameter int unsigned CPU_WIDTH      = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned BE_WIDTH       = CPU_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      if_req_valid,
  output logic                      if_req_ready,
  input  logic [MEM_ADDR_WIDTH-1:0] if_req_addr,
  output logic                      if_rsp_valid,
  input  logic                      if_rsp_ready,
  output logic [CPU_WIDTH-1:0]      if_rsp_data,

  input  logic                      d_req_valid,
  output logic                      d_req_ready,
  input  logic                      d_req_we,
  input  logic [BE_WIDTH-1:0]       d_req_be,
  input  logic [MEM_ADDR_WIDTH-1:0] d_req_addr,
  input  logic [CPU_WIDTH-1:0]      d_req_wdata,
  output logic                      d_rsp_valid,
  input  logic                      d_rsp_ready,
  output logic [CPU_WIDTH-1:0]      d_rsp_data,

  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_a,
  output logic [CPU_WIDTH-1:0]      mem_di,
  input  logic [CPU_WIDTH-1:0]      mem_spo
);

  localparam int unsigned LANE_W = 8;

  logic                      if_elig;
  logic                      d_elig;
  logic                      gnt_if;
  logic                      gnt_d;
  logic                      d_store;
  logic [CPU_WIDTH-1:0]      merged;
  logic [MEM_ADDR_WIDTH-1:0] a_q;

  // A slot is free when empty or being drained this cycle.
  assign if_elig = if_req_valid && (!if_rsp_valid || if_rsp_ready);
  assign d_elig  = d_req_valid  && (!d_rsp_valid  || d_rsp_ready);

`ifdef KAMACORE_ARB_ROUND_ROBIN_EN
  // rr_q = 1 means data wins the next contended cycle.
  logic rr_q;
  logic contended;

  assign contended = if_elig && d_elig;

  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (!rst) begin
      gnt_if = if_elig && (!d_elig || !rr_q);
      gnt_d  = d_elig  && (!if_elig || rr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (contended) begin
      rr_q <= gnt_if;
    end
  end
`else
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (!rst) begin
      gnt_d  = d_elig;
      gnt_if = if_elig && !d_elig;
    end
  end
`endif

  assign if_req_ready = gnt_if;
  assign d_req_ready  = gnt_d;
  assign d_store      = gnt_d && d_req_we;

  // Read-modify-write: enabled store lanes over the current RAM word.
  always_comb begin
    merged = mem_spo;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      if (d_req_be[i]) begin
        merged[i*LANE_W +: LANE_W] = d_req_wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // RAM port: granted address, otherwise the last one; non-writes echo the read word.
  always_comb begin
    mem_a  = a_q;
    mem_we = d_store;
    mem_di = mem_spo;
    if (gnt_d) begin
      mem_a = d_req_addr;
    end else if (gnt_if) begin
      mem_a = if_req_addr;
    end
    if (d_store) begin
      mem_di = merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
    end else if (gnt_d) begin
      a_q <= d_req_addr;
    end else if (gnt_if) begin
      a_q <= if_req_addr;
    end
  end

  // Fetch response slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
    end else if (gnt_if) begin
      if_rsp_valid <= 1'b1;
      if_rsp_data  <= mem_spo;
    end else if (if_rsp_ready) begin
      if_rsp_valid <= 1'b0;
    end
  end

  // Data response slot: load word or the word as written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
    end else if (gnt_d) begin
      d_rsp_valid <= 1'b1;
      d_rsp_data  <= d_req_we ? merged : mem_spo;
    end else if (d_rsp_ready) begin
      d_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kamacore_mem_arbiter.sv
// Directed bench for kamacore_mem_arbiter against a 16-word async-read RAM model.
module tb_kamacore_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
  logic [3:0]  if_req_addr;
  logic [31:0] if_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready;
  logic [3:0]  d_req_be, d_req_addr;
  logic [31:0] d_req_wdata, d_rsp_data;
  logic        mem_we;
  logic [3:0]  mem_a;
  logic [31:0] mem_di, mem_spo;
  logic        ram_load;
  logic [31:0] ram [16];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  kamacore_mem_arbiter #(.CPU_WIDTH(32), .MEM_ADDR_WIDTH(4), .BE_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_be(d_req_be), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .mem_we(mem_we), .mem_a(mem_a), .mem_di(mem_di), .mem_spo(mem_spo)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      1:       init_word = 32'h00708093;
      3:       init_word = 32'hCAFEF00D;
      5:       init_word = 32'h11223344;
      9:       init_word = 32'h99999999;
      default: init_word = 32'h10000000 | 32'(i);
    endcase
  endfunction

  assign mem_spo = ram[mem_a];

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
    end else if (mem_we) begin
      ram[mem_a] <= mem_di;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ifv;  logic [3:0] ifa;
    logic        dv;   logic dwe; logic [3:0] dbe; logic [3:0] da; logic [31:0] dwd;
    logic        e_ifr; logic e_dr; logic e_we; logic [3:0] e_a; logic [31:0] e_di;
    logic        e_ifv; logic [31:0] e_ifd;
    logic        e_dv;  logic [31:0] e_dd;
  } vec_t;

  function automatic vec_t mk(input logic ifv, input logic [3:0] ifa,
                              input logic dv, input logic dwe, input logic [3:0] dbe,
                              input logic [3:0] da, input logic [31:0] dwd,
                              input logic eifr, input logic edr, input logic ewe,
                              input logic [3:0] ea, input logic [31:0] edi,
                              input logic eifv, input logic [31:0] eifd,
                              input logic edv, input logic [31:0] edd);
    vec_t v;
    v.ifv = ifv; v.ifa = ifa; v.dv = dv; v.dwe = dwe; v.dbe = dbe; v.da = da; v.dwd = dwd;
    v.e_ifr = eifr; v.e_dr = edr; v.e_we = ewe; v.e_a = ea; v.e_di = edi;
    v.e_ifv = eifv; v.e_ifd = eifd; v.e_dv = edv; v.e_dd = edd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0; if_req_addr = 4'd0; if_rsp_ready = 1'b1;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_be = 4'd0; d_req_addr = 4'd0;
    d_req_wdata = 32'd0; d_rsp_ready = 1'b1;
  endtask

  vec_t vecs [13];

  initial begin
    vecs[0]  = mk(1, 4'd1, 0, 0, 4'h0, 4'd0, 32'h0,
                  1, 0, 0, 4'd1, 32'h00708093, 1, 32'h00708093, 0, 32'h0);
    vecs[1]  = mk(0, 4'd0, 1, 0, 4'h0, 4'd5, 32'h0,
                  0, 1, 0, 4'd5, 32'h11223344, 0, 32'h0, 1, 32'h11223344);
    vecs[2]  = mk(0, 4'd0, 1, 1, 4'b0110, 4'd5, 32'hAABBCCDD,
                  0, 1, 1, 4'd5, 32'h11BBCC44, 0, 32'h0, 1, 32'h11BBCC44);
    vecs[3]  = mk(0, 4'd0, 1, 0, 4'h0, 4'd5, 32'h0,
                  0, 1, 0, 4'd5, 32'h11BBCC44, 0, 32'h0, 1, 32'h11BBCC44);
    vecs[4]  = mk(0, 4'd0, 1, 1, 4'h0, 4'd3, 32'h01234567,
                  0, 1, 1, 4'd3, 32'hCAFEF00D, 0, 32'h0, 1, 32'hCAFEF00D);
    vecs[5]  = mk(0, 4'd0, 1, 0, 4'hF, 4'd3, 32'hFFFFFFFF,
                  0, 1, 0, 4'd3, 32'hCAFEF00D, 0, 32'h0, 1, 32'hCAFEF00D);
    vecs[6]  = mk(0, 4'd0, 0, 0, 4'h0, 4'd0, 32'h0,
                  0, 0, 0, 4'd3, 32'hCAFEF00D, 0, 32'h0, 0, 32'h0);
    vecs[7]  = mk(0, 4'd0, 1, 1, 4'hF, 4'd7, 32'hDEADBEEF,
                  0, 1, 1, 4'd7, 32'hDEADBEEF, 0, 32'h0, 1, 32'hDEADBEEF);
    vecs[8]  = mk(0, 4'd0, 1, 1, 4'b1000, 4'd2, 32'h55667788,
                  0, 1, 1, 4'd2, 32'h55000002, 0, 32'h0, 1, 32'h55000002);
`ifdef KAMACORE_ARB_ROUND_ROBIN_EN
    for (int k = 9; k < 13; k++) begin
      if (k % 2 == 1)
        vecs[k] = mk(1, 4'd1, 1, 0, 4'h0, 4'd7, 32'h0,
                     1, 0, 0, 4'd1, 32'h00708093, 1, 32'h00708093, 0, 32'h0);
      else
        vecs[k] = mk(1, 4'd1, 1, 0, 4'h0, 4'd7, 32'h0,
                     0, 1, 0, 4'd7, 32'hDEADBEEF, 0, 32'h0, 1, 32'hDEADBEEF);
    end
`else
    for (int k = 9; k < 13; k++)
      vecs[k] = mk(1, 4'd1, 1, 0, 4'h0, 4'd7, 32'h0,
                   0, 1, 0, 4'd7, 32'hDEADBEEF, 0, 32'h0, 1, 32'hDEADBEEF);
`endif

    // Reset state
    idle_inputs();
    rst = 1'b1; ram_load = 1'b1;
    tick(); tick();
    chk("rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
    chk("rst_d_rsp_valid",  32'(d_rsp_valid),  32'd0);
    chk("rst_if_rsp_data",  if_rsp_data, 32'd0);
    chk("rst_d_rsp_data",   d_rsp_data,  32'd0);
    chk("rst_mem_we",       32'(mem_we), 32'd0);
    chk("rst_mem_a",        32'(mem_a),  32'd0);
    rst = 1'b0; ram_load = 1'b0;
    tick();

    for (int k = 0; k < 13; k++) begin
      if_req_valid = vecs[k].ifv; if_req_addr = vecs[k].ifa;
      d_req_valid = vecs[k].dv; d_req_we = vecs[k].dwe; d_req_be = vecs[k].dbe;
      d_req_addr = vecs[k].da; d_req_wdata = vecs[k].dwd;
      #1;
      chk($sformatf("v%0d_if_req_ready", k), 32'(if_req_ready), 32'(vecs[k].e_ifr));
      chk($sformatf("v%0d_d_req_ready", k),  32'(d_req_ready),  32'(vecs[k].e_dr));
      chk($sformatf("v%0d_mem_we", k),       32'(mem_we),       32'(vecs[k].e_we));
      chk($sformatf("v%0d_mem_a", k),        32'(mem_a),        32'(vecs[k].e_a));
      chk($sformatf("v%0d_mem_di", k),       mem_di,            vecs[k].e_di);
      tick();
      chk($sformatf("v%0d_if_rsp_valid", k), 32'(if_rsp_valid), 32'(vecs[k].e_ifv));
      if (vecs[k].e_ifv) chk($sformatf("v%0d_if_rsp_data", k), if_rsp_data, vecs[k].e_ifd);
      chk($sformatf("v%0d_d_rsp_valid", k),  32'(d_rsp_valid),  32'(vecs[k].e_dv));
      if (vecs[k].e_dv) chk($sformatf("v%0d_d_rsp_data", k), d_rsp_data, vecs[k].e_dd);
    end
    chk("ram5_merged", ram[5], 32'h11BBCC44);
    chk("ram3_be0",    ram[3], 32'hCAFEF00D);

    // Backpressure on the data response
    idle_inputs();
    d_req_valid = 1'b1; d_req_addr = 4'd5;
    #1;
    chk("bp_load_ready", 32'(d_req_ready), 32'd1);
    tick();
    d_rsp_ready = 1'b0; d_req_addr = 4'd7;
    if_req_valid = 1'b1; if_req_addr = 4'd1;
    chk("bp_rsp_valid", 32'(d_rsp_valid), 32'd1);
    chk("bp_rsp_data",  d_rsp_data, 32'h11BBCC44);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_d_req_ready", k),  32'(d_req_ready),  32'd0);
      chk($sformatf("bp%0d_if_req_ready", k), 32'(if_req_ready), 32'd1);
      tick();
      chk($sformatf("bp%0d_d_rsp_valid", k),  32'(d_rsp_valid),  32'd1);
      chk($sformatf("bp%0d_d_rsp_data", k),   d_rsp_data, 32'h11BBCC44);
      chk($sformatf("bp%0d_if_rsp_valid", k), 32'(if_rsp_valid), 32'd1);
    end
    idle_inputs();
    tick();
    chk("bp_drained", 32'(d_rsp_valid), 32'd0);

    // Reset during a store grant, with a fetch response pending
    if_req_valid = 1'b1; if_req_addr = 4'd1; if_rsp_ready = 1'b0;
    tick();
    chk("rs_if_pending", 32'(if_rsp_valid), 32'd1);
    if_req_valid = 1'b0;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_be = 4'hF;
    d_req_addr = 4'd9; d_req_wdata = 32'h12345678;
    #1;
    chk("rs_we_before", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_we_now",       32'(mem_we),       32'd0);
    chk("rs_mem_a",        32'(mem_a),        32'd0);
    chk("rs_d_req_ready",  32'(d_req_ready),  32'd0);
    chk("rs_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
    chk("rs_d_rsp_valid",  32'(d_rsp_valid),  32'd0);
    chk("rs_if_rsp_data",  if_rsp_data, 32'd0);
    tick(); tick();
    chk("rs_ram9", ram[9], 32'h99999999);
    idle_inputs();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
